pc_unit: RTL and testbench



---
 rtl/pc_unit_pkg.sv | 19 +
 rtl/pc_unit_if.sv | 32 +++
 rtl/pc_page_latch.sv | 31 +++
 rtl/pc_unit.sv | 71 +++++++
 tb/tb_pc_unit.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program counter and its consumers (AGL).
// Provides the PC/IBUS width, the page field bounds and the reset PC.
package pc_unit_pkg;

  localparam int unsigned PC_WIDTH     = 16;
  localparam int unsigned PC_PAGE_BITS = 6;
  localparam int unsigned OFFSET_BITS  = PC_WIDTH - PC_PAGE_BITS;  // 10
  localparam int unsigned PAGE_LSB     = OFFSET_BITS;              // 10

  localparam logic [PC_WIDTH-1:0] PC_RESET_VAL = 16'hfff0;

  // Register update selected on each non-reset edge.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_op_e;

endpackage

// File: rtl/pc_unit_if.sv
// IBUS and control-strobe bundle between the sequencer (master) and the
// program counter (slave).
//   ibus_in   : value presented to the PC for a load
//   ibus_out  : PC value offered to IBUS
//   ibus_oe   : high when ibus_out must drive IBUS
//   nread_pc  : active-low, drive PC onto IBUS
//   nwrite_pc : active-low, load PC from ibus_in
//   ninc_pc   : active-low, increment PC
//   nend      : active-low instruction-end strobe
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
);
  logic [WIDTH-1:0] ibus_in;
  logic [WIDTH-1:0] ibus_out;
  logic             ibus_oe;
  logic             nread_pc;
  logic             nwrite_pc;
  logic             ninc_pc;
  logic             nend;

  modport master (
    output ibus_in, nread_pc, nwrite_pc, ninc_pc, nend,
    input  ibus_out, ibus_oe
  );

  modport slave (
    input  ibus_in, nread_pc, nwrite_pc, ninc_pc, nend,
    output ibus_out, ibus_oe
  );
endinterface

// File: rtl/pc_page_latch.sv
// Instruction-boundary snapshot register: captures d on every rising edge
// where nend is low, holds otherwise. Synchronous active-high reset.
//   clk, reset : clock and synchronous reset
//   nend       : active-low load strobe
//   d          : value to snapshot
//   q          : snapshot output
module pc_page_latch #(
  parameter int unsigned      W         = 6,
  parameter logic [W-1:0]     RESET_VAL = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         nend,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!nend) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RESET_VAL;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/pc_unit.sv
// Program counter for the CFT datapath. Loads from IBUS, increments, drives
// the PC onto IBUS, and snapshots the PC page at each instruction end for
// the AGL.
//   clk, reset   : clock and synchronous active-high reset
//   bus          : IBUS/strobe bundle (slave side)
//   pc           : current PC register
//   pc_page      : page snapshot (PC MSBs) taken on nend
//   err_conflict : sticky flag, load coincided with increment or read
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned          WIDTH     = PC_WIDTH,
  parameter int unsigned          PAGE_BITS = PC_PAGE_BITS,
  parameter logic [WIDTH-1:0]     RESET_PC  = PC_RESET_VAL
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_unit_if.slave             bus,
  output logic [WIDTH-1:0]     pc,
  output logic [PAGE_BITS-1:0] pc_page,
  output logic                 err_conflict
);
  localparam int unsigned PG_LSB = WIDTH - PAGE_BITS;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  pc_op_e           op;

  always_comb begin
    op = PC_HOLD;
    if (!bus.nwrite_pc)    op = PC_LOAD;
    else if (!bus.ninc_pc) op = PC_INC;

    pc_d = pc_q;
    unique case (op)
      PC_LOAD: pc_d = bus.ibus_in;
      PC_INC:  pc_d = pc_q + WIDTH'(1);
      default: pc_d = pc_q;
    endcase

    err_d = err_q | (!bus.nwrite_pc & (!bus.ninc_pc | !bus.nread_pc));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  // Snapshot uses the registered pc, so a same-edge load/increment is only
  // seen at the following instruction end.
  pc_page_latch #(
    .W         (PAGE_BITS),
    .RESET_VAL (RESET_PC[WIDTH-1:PG_LSB])
  ) u_page (
    .clk   (clk),
    .reset (reset),
    .nend  (bus.nend),
    .d     (pc_q[WIDTH-1:PG_LSB]),
    .q     (pc_page)
  );

  assign bus.ibus_out = pc_q;
  assign bus.ibus_oe  = ~bus.nread_pc;
  assign pc           = pc_q;
  assign err_conflict = err_q;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [5:0]  pc_page;
  logic        err_conflict;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  pc_unit_if #(.WIDTH(16)) bus ();

  pc_unit #(
    .WIDTH     (16),
    .PAGE_BITS (6),
    .RESET_PC  (16'hfff0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .pc           (pc),
    .pc_page      (pc_page),
    .err_conflict (err_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.ibus_in   = '0;
    bus.nread_pc  = 1'b1;
    bus.nwrite_pc = 1'b1;
    bus.ninc_pc   = 1'b1;
    bus.nend      = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_pc",   32'(pc), 32'h0000_fff0);
    chk("rst_page", 32'(pc_page), 32'h3f);
    chk("rst_oe",   32'(bus.ibus_oe), 32'h0);
    chk("rst_err",  32'(err_conflict), 32'h0);

    // Increment and wrap
    bus.nwrite_pc = 1'b0; bus.ibus_in = 16'hfffe;
    step();
    bus.nwrite_pc = 1'b1;
    chk("ld_fffe", 32'(pc), 32'h0000_fffe);
    bus.ninc_pc = 1'b0;
    step(); chk("inc_ffff", 32'(pc), 32'h0000_ffff);
    step(); chk("inc_wrap", 32'(pc), 32'h0000_0000);
    step(); chk("inc_0001", 32'(pc), 32'h0000_0001);
    bus.ninc_pc = 1'b1;
    chk("inc_page_hold", 32'(pc_page), 32'h3f);

    // Page snapshot takes the pre-edge pc
    bus.nwrite_pc = 1'b0; bus.ibus_in = 16'h03ff;
    step();
    bus.nwrite_pc = 1'b0; bus.nwrite_pc = 1'b1;
    chk("ld_03ff", 32'(pc), 32'h0000_03ff);
    bus.ninc_pc = 1'b0; bus.nend = 1'b0;
    step();
    bus.ninc_pc = 1'b1;
    chk("snap_pc",   32'(pc), 32'h0000_0400);
    chk("snap_pg0",  32'(pc_page), 32'h00);
    step();
    bus.nend = 1'b1;
    chk("snap_pg1",  32'(pc_page), 32'h01);

    // Mid-instruction jump
    bus.nwrite_pc = 1'b0; bus.ibus_in = 16'hfc12;
    step();
    bus.nwrite_pc = 1'b1;
    chk("jmp_pc",    32'(pc), 32'h0000_fc12);
    chk("jmp_pg_a",  32'(pc_page), 32'h01);
    step();
    chk("jmp_pg_b",  32'(pc_page), 32'h01);
    bus.nend = 1'b0;
    step();
    bus.nend = 1'b1;
    chk("jmp_pg_end", 32'(pc_page), 32'h3f);

    // Bus read, combinational
    bus.nwrite_pc = 1'b0; bus.ibus_in = 16'h1234;
    step();
    bus.nwrite_pc = 1'b1;
    bus.nread_pc = 1'b0;
    #1;
    chk("rd_oe",  32'(bus.ibus_oe), 32'h1);
    chk("rd_out", 32'(bus.ibus_out), 32'h0000_1234);
    bus.nread_pc = 1'b1;
    #1;
    chk("rd_oe_off", 32'(bus.ibus_oe), 32'h0);
    chk("rd_err",    32'(err_conflict), 32'h0);

    // Load + increment conflict
    bus.nwrite_pc = 1'b0; bus.ninc_pc = 1'b0; bus.ibus_in = 16'h0042;
    step();
    bus.nwrite_pc = 1'b1;
    chk("cf_pc",  32'(pc), 32'h0000_0042);
    chk("cf_err", 32'(err_conflict), 32'h1);
    step();
    bus.ninc_pc = 1'b1;
    chk("cf_inc",    32'(pc), 32'h0000_0043);
    chk("cf_sticky", 32'(err_conflict), 32'h1);
    step();
    chk("cf_sticky2", 32'(err_conflict), 32'h1);

    // Reset overrides an in-flight load and nend
    reset = 1'b1; bus.nwrite_pc = 1'b0; bus.nend = 1'b0; bus.ibus_in = 16'h5555;
    step();
    reset = 1'b0; bus.nwrite_pc = 1'b1; bus.nend = 1'b1;
    chk("rl_pc",   32'(pc), 32'h0000_fff0);
    chk("rl_page", 32'(pc_page), 32'h3f);
    chk("rl_err",  32'(err_conflict), 32'h0);

    // Read + write conflict: bus shows old pc, load still lands
    bus.nread_pc = 1'b0; bus.nwrite_pc = 1'b0; bus.ibus_in = 16'h0abc;
    #1;
    chk("rw_out_old", 32'(bus.ibus_out), 32'h0000_fff0);
    step();
    bus.nread_pc = 1'b1; bus.nwrite_pc = 1'b1;
    chk("rw_pc",  32'(pc), 32'h0000_0abc);
    chk("rw_err", 32'(err_conflict), 32'h1);
    chk("rw_page", 32'(pc_page), 32'h3f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
